// File: rtl/feistel_pkg.sv
// Shared types and helpers for the iterative generalised-Feistel engine.
package feistel_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Widest branch the helper functions handle; branches are zero-extended to this.
   localparam int unsigned MAX_W = 64;

   // Branch positions inside a block: x0 sits in the most significant slot.
   localparam int unsigned BR_X0 = 3;
   localparam int unsigned BR_X1 = 2;
   localparam int unsigned BR_X2 = 1;
   localparam int unsigned BR_X3 = 0;

   // Lowest bit of branch slot 'br' for branches 'w' bits wide.
   function automatic int unsigned br_lsb(input int unsigned br, input int unsigned w);
      return br * w;
   endfunction

   // Rotate the low 'w' bits of v left by r; bits above w come back as zero.
   function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                             input int unsigned w,
                                             input int unsigned r);
      logic [MAX_W-1:0] one;
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] vm;
      logic [MAX_W-1:0] res;
      one    = '0;
      one[0] = 1'b1;
      mask   = (w >= MAX_W) ? '1 : ((one << w) - one);
      vm     = v & mask;
      if (r == 0) begin
         res = vm;
      end else begin
         res = ((vm << r) | (vm >> (w - r))) & mask;
      end
      return res;
   endfunction

   // Keyed round function: mix in the key, then rotate.
   function automatic logic [MAX_W-1:0] f_mix(input logic [MAX_W-1:0] v,
                                              input logic [MAX_W-1:0] k,
                                              input int unsigned w,
                                              input int unsigned r);
      return rotl(v ^ k, w, r);
   endfunction

endpackage

// File: rtl/feistel_iter_core_round.sv
// One combinational generalised-Feistel round; mode selects the forward
// equations or their exact inverse.
module feistel_round
   import feistel_pkg::*;
#(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned ROT    = 0
) (
   input  logic                  mode,
   input  logic [4*WORD_W-1:0]   blk_i,
   input  logic [2*WORD_W-1:0]   rk,
   output logic [4*WORD_W-1:0]   blk_o
);

   localparam int unsigned L0 = br_lsb(BR_X0, WORD_W);
   localparam int unsigned L1 = br_lsb(BR_X1, WORD_W);
   localparam int unsigned L2 = br_lsb(BR_X2, WORD_W);
   localparam int unsigned L3 = br_lsb(BR_X3, WORD_W);

   logic [WORD_W-1:0] a0, a1, a2, a3;
   logic [WORD_W-1:0] k_hi, k_lo;
   logic [WORD_W-1:0] v_hi, v_lo;
   logic [WORD_W-1:0] f_hi, f_lo;
   logic [MAX_W-1:0]  wide_v_hi, wide_v_lo, wide_k_hi, wide_k_lo;
   logic [MAX_W-1:0]  mix_hi, mix_lo;

   // Both directions feed F from the branch that passes through unchanged,
   // so only the F operands and the output wiring depend on mode.
   always_comb begin
      a0   = blk_i[L0 +: WORD_W];
      a1   = blk_i[L1 +: WORD_W];
      a2   = blk_i[L2 +: WORD_W];
      a3   = blk_i[L3 +: WORD_W];
      k_hi = rk[WORD_W +: WORD_W];
      k_lo = rk[0 +: WORD_W];

      v_hi = mode ? a3 : a0;
      v_lo = mode ? a1 : a2;

      wide_v_hi = '0;
      wide_v_lo = '0;
      wide_k_hi = '0;
      wide_k_lo = '0;
      wide_v_hi[WORD_W-1:0] = v_hi;
      wide_v_lo[WORD_W-1:0] = v_lo;
      wide_k_hi[WORD_W-1:0] = k_hi;
      wide_k_lo[WORD_W-1:0] = k_lo;

      mix_hi = f_mix(wide_v_hi, wide_k_hi, WORD_W, ROT);
      mix_lo = f_mix(wide_v_lo, wide_k_lo, WORD_W, ROT);
      f_hi   = mix_hi[WORD_W-1:0];
      f_lo   = mix_lo[WORD_W-1:0];

      if (!mode) begin
         blk_o = {a1 ^ f_hi, a2, a3 ^ f_lo, a0};
      end else begin
         blk_o = {a3, a0 ^ f_hi, a1, a2 ^ f_lo};
      end
   end

endmodule

// File: rtl/feistel_iter_core.sv
// Iterative Feistel engine: accepts a block, applies ROUNDS keyed rounds one
// per clock through a single round datapath, then presents the result.
module feistel_iter_core
   import feistel_pkg::*;
#(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned ROUNDS = 16,
   parameter int unsigned ROT    = 0,
   parameter int unsigned IDX_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic [4*WORD_W-1:0]   din,
   output logic [IDX_W-1:0]      rk_idx,
   input  logic [2*WORD_W-1:0]   rk,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*WORD_W-1:0]   dout
);

   localparam logic [IDX_W-1:0] LAST    = IDX_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic [4*WORD_W-1:0]  blk_q, blk_d;
   logic [4*WORD_W-1:0]  round_out;

   feistel_round #(
      .WORD_W (WORD_W),
      .ROT    (ROT)
   ) u_round (
      .mode  (mode_q),
      .blk_i (blk_q),
      .rk    (rk),
      .blk_o (round_out)
   );

   // Key index depends only on registered state, so the external key
   // lookup never loops back through the round logic.
   always_comb begin
      rk_idx = '0;
      if (state_q == RUN) begin
         rk_idx = mode_q ? (LAST - cnt_q) : cnt_q;
      end
   end

   // Next-state, handshake and output decode; a retiring result and a new
   // block can share the same edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      blk_d     = blk_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      dout      = '0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               blk_d   = din;
               mode_d  = mode;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            blk_d = round_out;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            dout      = blk_q;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  blk_d   = din;
                  mode_d  = mode;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset drops any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         blk_q   <= blk_d;
      end
   end

endmodule
